// File: rtl/data_sram_ctrl.sv
// rtl/data_sram_ctrl.sv - MEM-stage data request responder driving a 32-bit async SRAM
module data_sram_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_data_i,
  input  logic              req_we_i,
  input  logic              req_re_i,
  input  logic [3:0]        req_mask_i,
  input  logic              pipe_hold_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [31:0]       sram_dq_i,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         dq_q;
  logic                dq_oe_q;
  logic                ce_n_q;
  logic                oe_n_q;
  logic                we_n_q;
  logic [3:0]          be_n_q;

  // Byte-offset and out-of-range address bits are not used by a word-wide SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr_i[31:ADDR_W+2], req_addr_i[1:0]};

  // Hold the pipeline while a request is being taken or is in flight; DONE releases it.
  assign stall_o = (state_q == S_IDLE) ? (req_re_i | req_we_i) : (state_q != S_DONE);

  assign rdata_o     = rdata_q;
  assign sram_addr_o = addr_q;
  assign sram_dq_o   = dq_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_be_n   = be_n_q;

  // Access sequencer; every SRAM pin is a register so pins only move on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 4'hF;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (req_we_i) begin
            addr_q <= req_addr_i[ADDR_W+1:2];
            dq_q   <= req_data_i;
            if (req_mask_i != 4'h0) begin
              state_q <= S_WR_SETUP;
              ce_n_q  <= 1'b0;
              be_n_q  <= ~req_mask_i;
              dq_oe_q <= 1'b1;
            end else begin
              // Nothing to store: finish without touching the SRAM.
              state_q <= S_DONE;
            end
          end else if (req_re_i) begin
            addr_q  <= req_addr_i[ADDR_W+1:2];
            state_q <= S_RD;
            ce_n_q  <= 1'b0;
            oe_n_q  <= 1'b0;
            be_n_q  <= 4'h0;
            dq_oe_q <= 1'b0;
          end
        end
        S_RD: begin
          if (cnt_q == RD_LAST) begin
            rdata_q <= sram_dq_i;
            state_q <= S_DONE;
            cnt_q   <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            be_n_q  <= 4'hF;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WR_SETUP: begin
          state_q <= S_WR_PULSE;
          cnt_q   <= '0;
          we_n_q  <= 1'b0;
        end
        S_WR_PULSE: begin
          if (cnt_q == WR_LAST) begin
            state_q <= S_WR_HOLD;
            cnt_q   <= '0;
            we_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WR_HOLD: begin
          // Data stays driven one cycle past we_n rising for hold time.
          state_q <= S_DONE;
          cnt_q   <= '0;
          ce_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          be_n_q  <= 4'hF;
        end
        S_DONE: begin
          cnt_q <= '0;
          if (!pipe_hold_i) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          dq_oe_q <= 1'b0;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          be_n_q  <= 4'hF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// tb/tb_data_sram_ctrl.sv - bench for data_sram_ctrl with an async SRAM model
module tb_data_sram_ctrl;

  localparam int ADDR_W  = 20;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;

  logic              clk;
  logic              rst;
  logic [31:0]       req_addr_i;
  logic [31:0]       req_data_i;
  logic              req_we_i;
  logic              req_re_i;
  logic [3:0]        req_mask_i;
  logic              pipe_hold_i;
  logic [31:0]       rdata_o;
  logic              stall_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0]       sram_dq_i;
  logic [31:0]       sram_dq_o;
  logic              sram_dq_oe;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [3:0]        sram_be_n;

  data_sram_ctrl #(.ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_we_i(req_we_i), .req_re_i(req_re_i), .req_mask_i(req_mask_i),
    .pipe_hold_i(pipe_hold_i),
    .rdata_o(rdata_o), .stall_o(stall_o),
    .sram_addr_o(sram_addr_o), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: 128 words, drives the bus only while ce_n and oe_n are both low.
  logic [31:0] mem [0:127];
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr_o[6:0]] : 32'hBAD0BAD0;

  always @(posedge clk) begin : sram_write
    logic [31:0] w;
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      w = mem[sram_addr_o[6:0]];
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) w[8*b +: 8] = sram_dq_o[8*b +: 8];
      mem[sram_addr_o[6:0]] <= w;
    end
  end

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Controller and SRAM must never drive the bus at the same time.
  always @(negedge clk) begin
    if (!rst && !sram_oe_n && sram_dq_oe) begin
      n_err++;
      $display("FAIL bus_conflict: got oe_n=0 dq_oe=1 expected no overlap");
    end
  end

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int                lat;
    int                ce_cyc;
    int                ce_first;
    int                we_cyc;
    int                we_first;
    int                oe_cyc;
    int                dqoe_cyc;
    logic [31:0]       rdata;
    logic [3:0]        be_n;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t sb[$];

  // Issue one request at a negedge in IDLE, follow it to DONE, optionally hold DONE,
  // then drop the request and step to the following IDLE cycle.
  task automatic run_req(input vec_t v, input int hold_cycles, input string tag);
    exp_t e;
    int cyc, ce_cnt, ce_first, we_cnt, we_first, oe_cnt, dqoe_cnt;
    logic [31:0] held;
    logic wr;
    wr = v.we && (v.mask != 4'h0);
    e.lat      = v.we ? ((v.mask == 4'h0) ? 1 : 3 + WR_WAIT) : 1 + RD_WAIT;
    e.ce_cyc   = v.we ? (wr ? 2 + WR_WAIT : 0) : RD_WAIT;
    e.ce_first = (e.ce_cyc > 0) ? 1 : -1;
    e.we_cyc   = wr ? WR_WAIT : 0;
    e.we_first = wr ? 2 : -1;
    e.oe_cyc   = v.we ? 0 : RD_WAIT;
    e.dqoe_cyc = wr ? 2 + WR_WAIT : 0;
    e.rdata    = v.exp_rdata;
    e.be_n     = v.we ? ~v.mask : 4'h0;
    e.addr     = v.addr[ADDR_W+1:2];
    sb.push_back(e);

    req_we_i = v.we; req_re_i = v.re; req_addr_i = v.addr;
    req_data_i = v.data; req_mask_i = v.mask;
    #1;
    chk({tag, "_stall_c0"}, 32'(stall_o), 32'd1);
    cyc = 0; ce_cnt = 0; ce_first = -1; we_cnt = 0; we_first = -1; oe_cnt = 0; dqoe_cnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!sram_ce_n) begin ce_cnt++; if (ce_first < 0) ce_first = cyc; end
      if (!sram_we_n) begin we_cnt++; if (we_first < 0) we_first = cyc; end
      if (!sram_oe_n) oe_cnt++;
      if (sram_dq_oe) dqoe_cnt++;
      if (cyc == 1 && !sram_ce_n) begin
        chk({tag, "_addr"}, 32'(sram_addr_o), 32'(e.addr));
        chk({tag, "_be_n"}, 32'(sram_be_n), 32'(e.be_n));
        if (wr) chk({tag, "_dq_o"}, sram_dq_o, v.data);
      end
    end while (stall_o && cyc < 40);

    e = sb.pop_front();
    chk({tag, "_latency"},  32'(cyc),      32'(e.lat));
    chk({tag, "_rdata"},    rdata_o,       e.rdata);
    chk({tag, "_ce_cyc"},   32'(ce_cnt),   32'(e.ce_cyc));
    chk({tag, "_ce_first"}, 32'(ce_first), 32'(e.ce_first));
    chk({tag, "_we_cyc"},   32'(we_cnt),   32'(e.we_cyc));
    chk({tag, "_we_first"}, 32'(we_first), 32'(e.we_first));
    chk({tag, "_oe_cyc"},   32'(oe_cnt),   32'(e.oe_cyc));
    chk({tag, "_dqoe_cyc"}, 32'(dqoe_cnt), 32'(e.dqoe_cyc));

    if (hold_cycles > 0) begin
      pipe_hold_i = 1'b1;
      held = rdata_o;
      for (int k = 0; k < hold_cycles; k++) begin
        @(negedge clk);
        chk({tag, "_hold_ce_n"},  32'(sram_ce_n), 32'd1);
        chk({tag, "_hold_stall"}, 32'(stall_o),   32'd0);
        chk({tag, "_hold_rdata"}, rdata_o,        held);
      end
      pipe_hold_i = 1'b0;
    end
    req_we_i = 1'b0; req_re_i = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_stall"}, 32'(stall_o), 32'd0);
  endtask

  vec_t tbl [10];

  initial begin
    n_vec = 0; n_err = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[4] = 32'hDEADBEEF;

    //          we    re    addr          data          mask     expected rdata_o
    tbl[0] = '{1'b0, 1'b1, 32'h8000_0010, 32'h0,        4'hF,    32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0101, 32'h5A5A5A5A, 4'b0010, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,        4'h0,    32'h10005A40};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0008, 32'hFFFFFFFF, 4'b0000, 32'h10005A40};
    tbl[4] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,        4'h0,    32'h10000002};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_000C, 32'h12345678, 4'b1111, 32'h10000002};
    tbl[6] = '{1'b0, 1'b1, 32'h0000_000C, 32'h0,        4'h0,    32'h12345678};
    tbl[7] = '{1'b1, 1'b0, 32'h0000_0014, 32'hAABBCCDD, 4'b1001, 32'h12345678};
    tbl[8] = '{1'b0, 1'b1, 32'h0000_0014, 32'h0,        4'h0,    32'hAA0000DD};
    tbl[9] = '{1'b0, 1'b1, 32'h0000_01FC, 32'h0,        4'h0,    32'h1000007F};

    rst = 1'b1; req_we_i = 1'b0; req_re_i = 1'b0; req_addr_i = '0;
    req_data_i = '0; req_mask_i = '0; pipe_hold_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_addr",  32'(sram_addr_o), 32'h0);
    chk("rst_dq_o",  sram_dq_o, 32'h0);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
    chk("rst_be_n",  32'(sram_be_n), 32'hF);
    chk("rst_stall", 32'(stall_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_req(tbl[i], 0, $sformatf("v%0d", i));

    // DONE held by another stall source with the read still presented.
    run_req(tbl[0], 3, "hold");
    run_req(tbl[2], 0, "after_hold");

    // Reset during the write pulse aborts the access at once.
    req_we_i = 1'b1; req_re_i = 1'b0; req_addr_i = 32'h0000_0020;
    req_data_i = 32'h0; req_mask_i = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_we_n_c2", 32'(sram_we_n), 32'd0);
    rst = 1'b1; req_we_i = 1'b0;
    @(negedge clk);
    chk("rstmid_we_n",  32'(sram_we_n),  32'd1);
    chk("rstmid_ce_n",  32'(sram_ce_n),  32'd1);
    chk("rstmid_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rstmid_stall", 32'(stall_o),    32'd0);
    chk("rstmid_rdata", rdata_o,         32'h0);
    rst = 1'b0;
    @(negedge clk);
    run_req(tbl[9], 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
